// File: rtl/print_bcd_feeder.sv
// Request FIFO plus iterative double-dabble converter feeding the overlay print port.
// Optional macro PRINT_HEX_BYPASS_EN adds req_hex to pass raw values through unconverted.
module print_bcd_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int REC_MAX    = 46,
    parameter int BIN_W      = 20
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic             resetMode,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_rec,
    input  logic [BIN_W-1:0] req_val,
`ifdef PRINT_HEX_BYPASS_EN
    input  logic             req_hex,
`endif
    output logic [7:0]       print_rec,
    output logic [24:0]      print_val,
    output logic             print_set,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on any rising edge where req_valid and
    // req_ready are both high; req_ready comes only from the registered count,
    // so it never depends on req_valid in the same cycle.

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SH_W  = 24 + BIN_W;

    localparam logic [7:0]       REC_MAX_L = 8'(REC_MAX);
    localparam logic [BIN_W-1:0] DEC_MAX   = BIN_W'(999999);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       LAST_IT   = 5'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HEX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_rec_q [FIFO_DEPTH];
    logic [BIN_W-1:0] mem_val_q [FIFO_DEPTH];
`ifdef PRINT_HEX_BYPASS_EN
    logic             mem_hex_q [FIFO_DEPTH];
`endif

    logic [SH_W-1:0]  shift_q, shift_adj, shift_d;
    logic [4:0]       iter_q;
    logic [7:0]       cur_rec_q;
    logic             ovf_q;
    logic [7:0]       print_rec_q;
    logic [24:0]      print_val_q;
    logic             print_set_q;
    logic [7:0]       drop_cnt_q;

    logic             in_range, accept, push, drop, pop;
    logic [BIN_W-1:0] head_val;
    logic             head_hex;

    assign req_ready = (count_q != FULL_CNT);
    assign in_range  = (req_rec < REC_MAX_L);
    assign accept    = req_valid & req_ready & ~resetMode;
    assign push      = accept & in_range;
    assign drop      = accept & ~in_range;
    assign pop       = (state_q == S_IDLE) & (count_q != '0) & ~resetMode;
    assign head_val  = mem_val_q[rd_ptr_q];
`ifdef PRINT_HEX_BYPASS_EN
    assign head_hex  = mem_hex_q[rd_ptr_q];
`else
    assign head_hex  = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset: only entries below count_q are ever read.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_rec_q[wr_ptr_q] <= req_rec;
            mem_val_q[wr_ptr_q] <= req_val;
`ifdef PRINT_HEX_BYPASS_EN
            mem_hex_q[wr_ptr_q] <= req_hex;
`endif
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST || resetMode) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // One double-dabble step: add 3 to each digit >= 5, then shift left.
    always_comb begin
        shift_adj = shift_q;
        for (int k = 0; k < 6; k++) begin
            if (shift_q[BIN_W + 4*k +: 4] >= 4'd5) begin
                shift_adj[BIN_W + 4*k +: 4] = shift_q[BIN_W + 4*k +: 4] + 4'd3;
            end
        end
        shift_d = shift_adj << 1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            iter_q      <= '0;
            cur_rec_q   <= '0;
            ovf_q       <= 1'b0;
            print_rec_q <= '0;
            print_val_q <= '0;
            print_set_q <= 1'b0;
        end else begin
            print_set_q <= 1'b0;
            if (resetMode) begin
                state_q <= S_IDLE;
                iter_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            cur_rec_q <= mem_rec_q[rd_ptr_q];
                            shift_q   <= {24'b0, head_val};
                            ovf_q     <= (head_val > DEC_MAX);
                            iter_q    <= '0;
                            state_q   <= head_hex ? S_HEX : S_CONV;
                        end
                    end
                    S_CONV: begin
                        shift_q <= shift_d;
                        iter_q  <= iter_q + 5'd1;
                        if (iter_q == LAST_IT) begin
                            print_rec_q <= cur_rec_q;
                            print_val_q <= ovf_q ? {1'b1, 24'h999999}
                                                 : {1'b0, shift_d[SH_W-1 -: 24]};
                            print_set_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                    S_HEX: begin
                        print_rec_q <= cur_rec_q;
                        print_val_q <= 25'(shift_q[BIN_W-1:0]);
                        print_set_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign print_rec = print_rec_q;
    assign print_val = print_val_q;
    assign print_set = print_set_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (count_q != '0) | (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_print_bcd_feeder.sv
// Directed bench for print_bcd_feeder: conversion, latency, burst/full, drop, flush, reset.
// Build with PRINT_HEX_BYPASS_EN to also exercise the hex bypass path.
module tb_print_bcd_feeder;

    logic        CLOCK_50;
    logic        RST;
    logic        resetMode;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_rec;
    logic [19:0] req_val;
`ifdef PRINT_HEX_BYPASS_EN
    logic        req_hex;
`endif
    logic [7:0]  print_rec;
    logic [24:0] print_val;
    logic        print_set;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic [1:0]  dbg_state;

    int n_chk  = 0;
    int n_pass = 0;

    logic [24:0] exp_q[$];

    print_bcd_feeder dut (
        .CLOCK_50  (CLOCK_50),
        .RST       (RST),
        .resetMode (resetMode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rec   (req_rec),
        .req_val   (req_val),
`ifdef PRINT_HEX_BYPASS_EN
        .req_hex   (req_hex),
`endif
        .print_rec (print_rec),
        .print_val (print_val),
        .print_set (print_set),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] rec, input logic [19:0] val);
        req_valid = 1'b1;
        req_rec   = rec;
        req_val   = val;
        step();
        req_valid = 1'b0;
    endtask

`ifdef PRINT_HEX_BYPASS_EN
    task automatic send_hex(input logic [7:0] rec, input logic [19:0] val);
        req_hex = 1'b1;
        send(rec, val);
        req_hex = 1'b0;
    endtask
`endif

    // Cycles from the accepting edge until print_set is seen (budget on timeout).
    task automatic wait_set(input int budget, output int cycles);
        cycles = 0;
        while (!print_set && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    task automatic count_sets(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (print_set) seen++;
        end
    endtask

    initial begin : stim
        int          cyc;
        int          seen;
        int          sent;
        int          got;
        int          full_at;
        int          t;
        int          last_t;
        logic        acc;
        logic [24:0] e;
        logic [19:0] tv [3];
        logic [24:0] te [3];

        RST = 1'b1; resetMode = 1'b0; req_valid = 1'b0; req_rec = '0; req_val = '0;
`ifdef PRINT_HEX_BYPASS_EN
        req_hex = 1'b0;
`endif
        step();
        step();
        RST = 1'b0;

        // reset state
        chk("rst_print_rec", 32'(print_rec), 32'h0);
        chk("rst_print_val", 32'(print_val), 32'h0);
        chk("rst_print_set", 32'(print_set), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);

        // basic conversion and latency
        send(8'd5, 20'd123456);
        chk("conv_busy", 32'(busy), 32'h1);
        wait_set(40, cyc);
        chk("conv_latency", 32'(cyc), 32'd21);
        chk("conv_rec", 32'(print_rec), 32'd5);
        chk("conv_val", 32'(print_val), 32'h0123456);
        step();
        chk("conv_pulse_end", 32'(print_set), 32'h0);
        chk("conv_val_hold", 32'(print_val), 32'h0123456);

        // zero, largest in-range, and overflow
        tv[0] = 20'd0;       te[0] = 25'h0000000;
        tv[1] = 20'd999999;  te[1] = 25'h0999999;
        tv[2] = 20'd1048575; te[2] = 25'h1999999;
        for (int i = 0; i < 3; i++) begin
            send(8'(10 + i), tv[i]);
            wait_set(40, cyc);
            chk("edge_latency", 32'(cyc), 32'd21);
            chk("edge_rec", 32'(print_rec), 32'(10 + i));
            chk("edge_val", 32'(print_val), 32'(te[i]));
            step();
        end

        // burst of six with req_valid held high
        for (int i = 1; i <= 6; i++) exp_q.push_back(25'(i));
        sent = 0; got = 0; full_at = -1; t = 0; last_t = -1;
        while (got < 6 && t < 300) begin
            if (sent < 6) begin
                req_valid = 1'b1;
                req_rec   = 8'd9;
                req_val   = 20'(sent + 1);
                acc       = req_ready;
            end else begin
                req_valid = 1'b0;
                acc       = 1'b0;
            end
            step();
            t++;
            if (acc) sent++;
            if (!req_ready && full_at < 0) full_at = sent;
            if (print_set && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("burst_val", 32'(print_val), 32'(e));
                if (last_t >= 0) chk("burst_gap", 32'(t - last_t), 32'd21);
                else chk("burst_first", 32'(t), 32'd22);
                last_t = t;
                got++;
            end
        end
        req_valid = 1'b0;
        chk("burst_full_after", 32'(full_at), 32'd5);
        chk("burst_sent", 32'(sent), 32'd6);
        chk("burst_got", 32'(got), 32'd6);
        step();
        chk("burst_idle", 32'(busy), 32'h0);

        // out-of-range drop and saturation
        send(8'd46, 20'd5);
        chk("drop_busy", 32'(busy), 32'h0);
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
        count_sets(25, seen);
        chk("drop_no_set", 32'(seen), 32'd0);
        req_valid = 1'b1; req_rec = 8'd200; req_val = 20'd1;
        for (int i = 0; i < 253; i++) step();
        chk("drop_cnt254", 32'(drop_cnt), 32'd254);
        for (int i = 0; i < 3; i++) step();
        req_valid = 1'b0;
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // flush mid-conversion with two queued, colliding with a request
        send(8'd1, 20'd111);
        send(8'd2, 20'd222);
        send(8'd3, 20'd333);
        for (int i = 0; i < 7; i++) step();
        resetMode = 1'b1;
        req_valid = 1'b1; req_rec = 8'd4; req_val = 20'd444;
        step();
        resetMode = 1'b0;
        req_valid = 1'b0;
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_ready", 32'(req_ready), 32'h1);
        chk("flush_set", 32'(print_set), 32'h0);
        chk("flush_drop_kept", 32'(drop_cnt), 32'd255);
        chk("flush_val_hold", 32'(print_val), 32'h0000006);
        count_sets(40, seen);
        chk("flush_no_set", 32'(seen), 32'd0);

        // synchronous reset mid-conversion
        send(8'd3, 20'd1000);
        for (int i = 0; i < 5; i++) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst2_busy", 32'(busy), 32'h0);
        chk("rst2_drop", 32'(drop_cnt), 32'h0);
        chk("rst2_val", 32'(print_val), 32'h0);
        chk("rst2_rec", 32'(print_rec), 32'h0);
        chk("rst2_ready", 32'(req_ready), 32'h1);
        count_sets(30, seen);
        chk("rst2_no_set", 32'(seen), 32'd0);

`ifdef PRINT_HEX_BYPASS_EN
        // hex bypass: emitted right after the pop
        send_hex(8'd4, 20'hABCDE);
        chk("hex_set_e0", 32'(print_set), 32'h0);
        step();
        chk("hex_set_e1", 32'(print_set), 32'h0);
        step();
        chk("hex_set_e2", 32'(print_set), 32'h1);
        chk("hex_val", 32'(print_val), 32'h00ABCDE);
        chk("hex_rec", 32'(print_rec), 32'd4);
        step();
`endif

        // final report
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/print_bcd_feeder.md
Name: print_bcd_feeder

Overview:
- Upstream stage of the on-screen number overlay.
- Accepts (record index, 20-bit binary value) requests from neural-net result producers and queues them in a small FIFO.
- Converts each value to 6-digit packed BCD with an iterative shift-add-3 (double-dabble) FSM.
- Drives the overlay's print_rec / print_val / print_set write port, so values display in decimal instead of hex.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of two, ≥2)
- REC_MAX, 46, number of valid display records; rec ≥ REC_MAX is dropped
- BIN_W, 20, binary input width (fixed at 20; the iteration count equals BIN_W)

Ports:
- CLOCK_50  in  1  system clock
- RST  in  1  synchronous reset, active-high
- resetMode  in  1  flush: clears FIFO and aborts conversion
- req_valid  in  1  request strobe
- req_ready  out  1  FIFO not full
- req_rec  in  8  target display record
- req_val  in  20  unsigned binary value
- print_rec  out  8  record index to overlay
- print_val  out  25  [23:0] six BCD digits, [24] overflow marker
- print_set  out  1  one-cycle write strobe to overlay
- busy  out  1  FIFO non-empty or FSM not IDLE
- drop_cnt  out  8  saturating count of dropped out-of-range requests

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state changes occur on the rising edge of CLOCK_50; RST is sampled only there.
- Reset values:
  - FIFO empty; FSM = IDLE.
  - print_rec = 0, print_val = 0, print_set = 0, drop_cnt = 0.
  - req_ready = 1, busy = 0.
- Accept:
  - A request is accepted on an edge where req_valid & req_ready.
  - If req_rec ≥ REC_MAX, the request is not stored and drop_cnt increments, saturating at 255.
  - req_ready is derived from the registered count (not full). Push and pop on the same edge are legal; count is unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head. Load shift register = {24'b0, val}, latch rec, iter = 0. Go to CONV.
  - CONV: each edge, first add 3 to every BCD nibble ≥ 5, then shift the whole {bcd, bin} register left by 1; iter++.
  - On the edge completing iteration 20: register the outputs and go to IDLE. There is no separate EMIT state.
- Overflow rule: if the original value > 999999, print_val = {1'b1, 24'h999999}. The overlay's top digit then shows "1" as an overflow flag. Otherwise print_val[24] = 0.
- print_set: high for exactly one cycle, together with print_rec and print_val; deasserts the next edge. print_rec and print_val hold until the next emit.
- Latency: for a request accepted at edge E into an empty FIFO with the FSM idle:
  - pop at E+1;
  - CONV iterations on edges E+2 .. E+21;
  - print_set is visible in the cycle following edge E+21.
- Throughput: one result per 21 cycles (a new pop can occur at E+22). Order is strictly FIFO.
- resetMode:
  - On an edge with resetMode = 1: FIFO is emptied, FSM goes to IDLE, any in-flight result is discarded (no print_set), print_set is forced to 0.
  - resetMode has priority over an accept on that edge; the request is not stored.
  - drop_cnt is not cleared.
- RST mid-conversion: same as resetMode, and additionally restores every reset value.
- Full boundary: when the FIFO is full, req_ready = 0 and valid is ignored; no overwrite occurs.
- Empty boundary: when the FIFO is empty, the FSM stays in IDLE.

Optional Feature:
- Macro: PRINT_HEX_BYPASS_EN.
- When defined:
  - Extra input req_hex (1 bit) is stored per FIFO entry.
  - Entries with req_hex = 1 skip CONV. print_val = {5'b0, val} is emitted on the edge after the pop (latency E+2).
  - No overflow rule is applied to these entries.
- When undefined: the port is absent and every entry is converted.

Test Plan:
- Convert: rec=5, val=123456 accepted at edge 0 → print_set in the cycle after edge 21, print_rec = 5, print_val = 25'h0123456; single-cycle pulse.
- Zero and max: val=0 → 25'h0000000; val=999999 → 25'h0999999; val=1048575 → 25'h1999999.
- Burst: req_valid held high for 6 requests, vals 1..6:
  - req_ready drops when the FIFO holds 4 entries;
  - all 6 are eventually accepted;
  - print_val = 1..6 in order, 21 cycles apart.
- Drop: rec=46 → no print_set, drop_cnt = 1. Then 256 further drops → drop_cnt stays 255.
- Flush: resetMode pulsed at edge 10 of a conversion with 2 entries queued → no print_set ever; busy = 0 after that edge; req_ready = 1.
- Bypass (PRINT_HEX_BYPASS_EN): req_hex = 1, val = 20'hABCDE → print_val = 25'h00ABCDE in the cycle after edge 2.
